// File: rtl/ysyx_22041752_wb_arbiter.sv
// Write-back arbiter: merges ALU and long-latency results into one registered RF write per cycle
// and tracks outstanding long-latency destinations. Optional bypass: YSYX_22041752_WB_BYPASS_EN.
module ysyx_22041752_wb_arbiter #(
    parameter int XLEN = 64,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lng_valid,
    output logic            lng_ready,
    input  logic [4:0]      lng_rd,
    input  logic [XLEN-1:0] lng_data,
    input  logic            iss_valid,
    input  logic [4:0]      iss_rd,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic            rs1_busy,
    output logic            rs2_busy,
`ifdef YSYX_22041752_WB_BYPASS_EN
    input  logic [XLEN-1:0] rf_data_r1,
    input  logic [XLEN-1:0] rf_data_r2,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
`endif
    output logic            rf_we,
    output logic [4:0]      rf_addr_w,
    output logic [XLEN-1:0] rf_data_w,
    output logic            sb_err
);

    logic            hold_valid_reg, hold_valid_next;
    logic [4:0]      hold_rd_reg, hold_rd_next;
    logic [XLEN-1:0] hold_data_reg, hold_data_next;
    logic            rf_we_reg;
    logic [4:0]      rf_addr_w_reg;
    logic [XLEN-1:0] rf_data_w_reg;
    logic            sb_err_reg, sb_err_next;
    logic [NREG-1:0] busy_reg, busy_next;

    logic            lng_acc;
    logic            sel_valid, sel_long;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_data;
    logic            busy_set, busy_clr;

    assign lng_ready = !hold_valid_reg && !rst;
    assign lng_acc   = lng_valid && lng_ready;

    always_comb begin
        sel_valid       = 1'b0;
        sel_long        = 1'b0;
        sel_rd          = '0;
        sel_data        = '0;
        hold_valid_next = hold_valid_reg;
        hold_rd_next    = hold_rd_reg;
        hold_data_next  = hold_data_reg;
        if (alu_valid) begin
            sel_valid = 1'b1;
            sel_rd    = alu_rd;
            sel_data  = alu_data;
            // A long result arriving alongside an ALU result is parked until a free cycle.
            if (lng_acc) begin
                hold_valid_next = 1'b1;
                hold_rd_next    = lng_rd;
                hold_data_next  = lng_data;
            end
        end else if (hold_valid_reg) begin
            sel_valid       = 1'b1;
            sel_long        = 1'b1;
            sel_rd          = hold_rd_reg;
            sel_data        = hold_data_reg;
            hold_valid_next = 1'b0;
        end else if (lng_acc) begin
            sel_valid = 1'b1;
            sel_long  = 1'b1;
            sel_rd    = lng_rd;
            sel_data  = lng_data;
        end
    end

    assign busy_set    = iss_valid && (iss_rd != 5'd0);
    assign busy_clr    = sel_long && (sel_rd != 5'd0);
    assign sb_err_next = busy_set && busy_reg[iss_rd] && !(busy_clr && (sel_rd == iss_rd));

    // Per-register scoreboard update; a same-cycle set overrides the retire clear.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
            if (gi == 0) begin : g_x0
                assign busy_next[gi] = 1'b0;
            end else begin : g_xn
                assign busy_next[gi] = (busy_set && (iss_rd == 5'(gi))) ? 1'b1 :
                                       (busy_clr && (sel_rd == 5'(gi))) ? 1'b0 :
                                       busy_reg[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid_reg <= 1'b0;
            hold_rd_reg    <= '0;
            hold_data_reg  <= '0;
            rf_we_reg      <= 1'b0;
            rf_addr_w_reg  <= '0;
            rf_data_w_reg  <= '0;
            sb_err_reg     <= 1'b0;
            busy_reg       <= '0;
        end else begin
            hold_valid_reg <= hold_valid_next;
            hold_rd_reg    <= hold_rd_next;
            hold_data_reg  <= hold_data_next;
            rf_we_reg      <= sel_valid && (sel_rd != 5'd0);
            if (sel_valid && (sel_rd != 5'd0)) begin
                rf_addr_w_reg <= sel_rd;
                rf_data_w_reg <= sel_data;
            end
            sb_err_reg     <= sb_err_next;
            busy_reg       <= busy_next;
        end
    end

    assign rf_we     = rf_we_reg;
    assign rf_addr_w = rf_addr_w_reg;
    assign rf_data_w = rf_data_w_reg;
    assign sb_err    = sb_err_reg;

`ifdef YSYX_22041752_WB_BYPASS_EN
    logic fwd1, fwd2;
    assign fwd1     = rf_we_reg && (rf_addr_w_reg == rs1_addr) && (rs1_addr != 5'd0);
    assign fwd2     = rf_we_reg && (rf_addr_w_reg == rs2_addr) && (rs2_addr != 5'd0);
    assign rs1_data = fwd1 ? rf_data_w_reg : rf_data_r1;
    assign rs2_data = fwd2 ? rf_data_w_reg : rf_data_r2;
    assign rs1_busy = (rs1_addr != 5'd0) && busy_reg[rs1_addr];
    assign rs2_busy = (rs2_addr != 5'd0) && busy_reg[rs2_addr];
`else
    // The pending output-register write still stalls readers until the RF commits it.
    assign rs1_busy = (rs1_addr != 5'd0) &&
                      (busy_reg[rs1_addr] || (rf_we_reg && (rf_addr_w_reg == rs1_addr)));
    assign rs2_busy = (rs2_addr != 5'd0) &&
                      (busy_reg[rs2_addr] || (rf_we_reg && (rf_addr_w_reg == rs2_addr)));
`endif

endmodule

// File: tb/tb_ysyx_22041752_wb_arbiter.sv
// Testbench for ysyx_22041752_wb_arbiter: directed vectors, a queue-based reference model
// checked every cycle, plus hand-computed literal checks.
module tb_ysyx_22041752_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, lng_valid, iss_valid;
    logic [4:0]  alu_rd, lng_rd, iss_rd, rs1_addr, rs2_addr;
    logic [63:0] alu_data, lng_data;
    logic        lng_ready, rs1_busy, rs2_busy, rf_we, sb_err;
    logic [4:0]  rf_addr_w;
    logic [63:0] rf_data_w;
`ifdef YSYX_22041752_WB_BYPASS_EN
    logic [63:0] rf_data_r1 = 64'h5555, rf_data_r2 = 64'h6666;
    logic [63:0] rs1_data, rs2_data;
`endif

    int passed = 0;
    int total  = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    ysyx_22041752_wb_arbiter dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .lng_valid(lng_valid), .lng_ready(lng_ready), .lng_rd(lng_rd), .lng_data(lng_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
`ifdef YSYX_22041752_WB_BYPASS_EN
        .rf_data_r1(rf_data_r1), .rf_data_r2(rf_data_r2), .rs1_data(rs1_data), .rs2_data(rs2_data),
`endif
        .rf_we(rf_we), .rf_addr_w(rf_addr_w), .rf_data_w(rf_data_w), .sb_err(sb_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: waiting long results in a queue, busy as a plain bit table.
    typedef struct { logic [4:0] rd; logic [63:0] data; } res_t;
    res_t        longq[$];
    res_t        r;
    bit          m_busy[32];
    bit          m_we, m_err, w, is_long;
    logic [4:0]  m_addr, wrd;
    logic [63:0] m_data, wd;

    always @(posedge clk) begin
        if (rst) begin
            longq.delete();
            foreach (m_busy[i]) m_busy[i] = 0;
            m_we = 0; m_err = 0; m_addr = 0; m_data = 0;
        end else begin
            w = 0; is_long = 0; wrd = 0; wd = 0;
            if (alu_valid) begin
                w = 1; wrd = alu_rd; wd = alu_data;
                if (lng_valid && longq.size() == 0) longq.push_back('{lng_rd, lng_data});
            end else if (longq.size() != 0) begin
                r = longq.pop_front(); w = 1; is_long = 1; wrd = r.rd; wd = r.data;
            end else if (lng_valid) begin
                w = 1; is_long = 1; wrd = lng_rd; wd = lng_data;
            end
            // Retire before issue so that a same-cycle reissue ends busy and is not an error.
            if (is_long && wrd != 0) m_busy[wrd] = 0;
            m_err = 0;
            if (iss_valid && iss_rd != 0) begin
                m_err = m_busy[iss_rd];
                m_busy[iss_rd] = 1;
            end
            m_we = w && (wrd != 0);
            if (m_we) begin m_addr = wrd; m_data = wd; end
        end
    end

    function automatic bit exp_busy(input logic [4:0] a);
`ifdef YSYX_22041752_WB_BYPASS_EN
        return (a != 0) && m_busy[a];
`else
        return (a != 0) && (m_busy[a] || (m_we && m_addr == a));
`endif
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_rf_we", rf_we, m_we);
            check("m_rf_addr_w", rf_addr_w, m_addr);
            check("m_rf_data_w", rf_data_w, m_data);
            check("m_sb_err", sb_err, m_err);
            check("m_lng_ready", lng_ready, (longq.size() == 0) && !rst);
            check("m_rs1_busy", rs1_busy, exp_busy(rs1_addr));
            check("m_rs2_busy", rs2_busy, exp_busy(rs2_addr));
`ifdef YSYX_22041752_WB_BYPASS_EN
            check("m_rs1_data", rs1_data,
                  (m_we && m_addr == rs1_addr && rs1_addr != 0) ? m_data : rf_data_r1);
            check("m_rs2_data", rs2_data,
                  (m_we && m_addr == rs2_addr && rs2_addr != 0) ? m_data : rf_data_r2);
`endif
        end
    end

    task automatic idle();
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        lng_valid = 0; lng_rd = 0; lng_data = 0;
        iss_valid = 0; iss_rd = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1; idle(); rs1_addr = 0; rs2_addr = 0;
        tick(); tick();
        check("rst_rf_we", rf_we, 1'b0);
        check("rst_rf_addr_w", rf_addr_w, 5'd0);
        check("rst_rf_data_w", rf_data_w, 64'd0);
        check("rst_sb_err", sb_err, 1'b0);
        check("rst_lng_ready", lng_ready, 1'b0);
        rst = 0; #1;
        check("post_rst_lng_ready", lng_ready, 1'b1);
        chk_en = 1;

        // ALU only
        alu_valid = 1; alu_rd = 5; alu_data = 64'h1234;
        tick(); idle();
        $display("txn alu x5 <= 1234: rf_we=%0b addr=%0d data=%0h", rf_we, rf_addr_w, rf_data_w);
        check("alu_we", rf_we, 1'b1);
        check("alu_addr", rf_addr_w, 5'd5);
        check("alu_data", rf_data_w, 64'h1234);
        tick();
        check("alu_we_off", rf_we, 1'b0);

        // ALU and long collide
        alu_valid = 1; alu_rd = 3; alu_data = 64'hA;
        lng_valid = 1; lng_rd = 7; lng_data = 64'hB;
        tick(); idle();
        $display("txn collide alu x3 / lng x7: addr=%0d ready=%0b", rf_addr_w, lng_ready);
        check("col1_addr", rf_addr_w, 5'd3);
        check("col1_data", rf_data_w, 64'hA);
        check("col1_ready", lng_ready, 1'b0);
        tick();
        check("col2_we", rf_we, 1'b1);
        check("col2_addr", rf_addr_w, 5'd7);
        check("col2_data", rf_data_w, 64'hB);
        check("col2_ready", lng_ready, 1'b1);

        // Scoreboard set and retire
        iss_valid = 1; iss_rd = 9;
        tick(); idle(); rs1_addr = 9; #1;
        $display("txn issue x9: rs1_busy=%0b", rs1_busy);
        check("sb_busy9", rs1_busy, 1'b1);
        lng_valid = 1; lng_rd = 9; lng_data = 64'h99;
        tick(); idle();
        $display("txn retire x9: rf_we=%0b rs1_busy=%0b", rf_we, rs1_busy);
        check("sb_wr9_addr", rf_addr_w, 5'd9);
`ifdef YSYX_22041752_WB_BYPASS_EN
        check("sb_wr9_busy", rs1_busy, 1'b0);
        check("sb_wr9_fwd", rs1_data, 64'h99);
`else
        check("sb_wr9_busy", rs1_busy, 1'b1);
`endif
        tick();
        check("sb_after9_busy", rs1_busy, 1'b0);

        // x0 handling
        alu_valid = 1; alu_rd = 0; alu_data = 64'h1;
        tick(); idle();
        check("x0_alu_we", rf_we, 1'b0);
        lng_valid = 1; lng_rd = 0; lng_data = 64'h2;
        tick(); idle();
        check("x0_lng_we", rf_we, 1'b0);
        iss_valid = 1; iss_rd = 0;
        tick(); idle(); rs1_addr = 0; #1;
        $display("txn x0 ops: rf_we=%0b rs1_busy=%0b", rf_we, rs1_busy);
        check("x0_busy", rs1_busy, 1'b0);

        // Double issue, then same-cycle retire plus reissue
        rs2_addr = 4;
        iss_valid = 1; iss_rd = 4;
        tick();
        tick(); idle();
        $display("txn double issue x4: sb_err=%0b rs2_busy=%0b", sb_err, rs2_busy);
        check("dbl_err", sb_err, 1'b1);
        check("dbl_busy", rs2_busy, 1'b1);
        tick();
        check("dbl_err_once", sb_err, 1'b0);
        lng_valid = 1; lng_rd = 4; lng_data = 64'h44;
        iss_valid = 1; iss_rd = 4;
        tick(); idle();
        check("reiss_err", sb_err, 1'b0);
        tick();
        $display("txn retire+reissue x4: sb_err=%0b rs2_busy=%0b", sb_err, rs2_busy);
        check("reiss_busy", rs2_busy, 1'b1);
        lng_valid = 1; lng_rd = 4; lng_data = 64'h45;
        tick(); idle();
        tick();
        check("x4_clear", rs2_busy, 1'b0);

        // Reset while a result is held and x12 is busy
        iss_valid = 1; iss_rd = 12;
        tick(); idle();
        alu_valid = 1; alu_rd = 1; alu_data = 64'h11;
        lng_valid = 1; lng_rd = 12; lng_data = 64'hCC;
        tick(); idle();
        check("rsthold_ready", lng_ready, 1'b0);
        rst = 1;
        tick(); rst = 0; #1;
        check("rstmid_we", rf_we, 1'b0);
        check("rstmid_ready", lng_ready, 1'b1);
        rs1_addr = 12;
        tick();
        $display("txn reset mid-op: rf_we=%0b rs1_busy=%0b ready=%0b", rf_we, rs1_busy, lng_ready);
        check("rstmid_we2", rf_we, 1'b0);
        check("rstmid_busy12", rs1_busy, 1'b0);
        tick();

        chk_en = 0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
